// File: rtl/ltc2387_adc_interface_if.sv
`timescale 1ns/1ps
// Pin-level and result bundle between the LTC2387 controller (master)
// and the ADC pins / acquisition logic (slave).
interface ltc2387_adc_interface_if #(
  parameter int ADC_WIDTH = 18
);
  logic                 cnv;
  logic                 clk;
  logic                 tl;
  logic                 dco;
  logic                 da;
  logic                 db;
  logic [ADC_WIDTH-1:0] adc_data_out;
  logic                 adc_data_valid;

  modport master (
    output cnv, clk, tl, adc_data_out, adc_data_valid,
    input  dco, da, db
  );

  modport slave (
    input  cnv, clk, tl, adc_data_out, adc_data_valid,
    output dco, da, db
  );
endinterface

// File: rtl/ltc2387_adc_interface.sv
`timescale 1ns/1ps
// LTC2387 two-lane DDR controller: drives CNV and a gated CLK burst, then
// assembles the DCO-qualified DA/DB lanes into a parallel word.
module ltc2387_adc_interface #(
  parameter int ADC_WIDTH       = 18,
  parameter int SYS_CLK_FREQ    = 200_000_000,
  parameter int T_FIRSTCLK      = int'((64'd65 * 64'(SYS_CLK_FREQ)) / 64'd1_000_000_000),
  parameter int CNV_HIGH_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                   sys_clk_int,
  input  logic                   reset_int,
  input  logic                   data_clk_int,
  input  logic                   trig_int,
  ltc2387_adc_interface_if.master adc
);

  localparam int HALF       = ADC_WIDTH / 2;
  localparam int CLK_CYCLES = 4 * ((ADC_WIDTH + 3) / 4);
  localparam int MAX_A      = (T_FIRSTCLK > CLK_CYCLES) ? T_FIRSTCLK : CLK_CYCLES;
  localparam int CNT_MAX    = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int EV_W       = $clog2(HALF + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CNV_HIGH   = 3'd1,
    WAIT_FIRST = 3'd2,
    CLOCKING   = 3'd3,
    WAIT_DATA  = 3'd4,
    DONE       = 3'd5
  } state_t;

  // dco[2] is the extra stage behind the 2-FF chain, used only for edge detection.
  typedef struct packed {
    logic       trig;
    logic       trig_prev;
    logic [2:0] dco;
    logic [1:0] da;
    logic [1:0] db;
  } cond_t;

  // Same net as sys_clk_int; kept only for pin compatibility.
  logic unused_data_clk;
  assign unused_data_clk = data_clk_int;

  cond_t                cond_q, cond_d;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [EV_W-1:0]      ev_cnt_q, ev_cnt_d;
  logic [ADC_WIDTH-1:0] shift_q, shift_d;
  logic [ADC_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 cnv_q, cnv_d;
  logic                 clk_q, clk_d;
  logic                 start;
  logic                 capture;

  always_comb begin
    cond_d.trig      = trig_int;
    cond_d.trig_prev = cond_q.trig;
    cond_d.dco       = {cond_q.dco[1:0], adc.dco};
    cond_d.da        = {cond_q.da[0], adc.da};
    cond_d.db        = {cond_q.db[0], adc.db};
  end

  assign start   = cond_q.trig & ~cond_q.trig_prev;
  assign capture = cond_q.dco[1] ^ cond_q.dco[2];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    ev_cnt_d = ev_cnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;

    if (capture && (state_q != IDLE) && (ev_cnt_q < EV_W'(HALF))) begin
      shift_d  = {shift_q[ADC_WIDTH-3:0], cond_q.da[1], cond_q.db[1]};
      ev_cnt_d = ev_cnt_q + EV_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d  = CNV_HIGH;
          ev_cnt_d = '0;
        end
      end
      CNV_HIGH: begin
        if (cnt_q == CNT_W'(CNV_HIGH_CYCLES - 1)) state_d = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (cnt_q == CNT_W'(T_FIRSTCLK - 1)) begin
          state_d = CLOCKING;
          cnt_d   = '0;
        end
      end
      CLOCKING: begin
        if (cnt_q == CNT_W'(CLK_CYCLES - 1)) begin
          state_d = WAIT_DATA;
          cnt_d   = '0;
        end
      end
      WAIT_DATA: begin
        if (ev_cnt_q == EV_W'(HALF))                  state_d = DONE;
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin outputs decode the next state so they leave a flop, free of decode glitches.
    cnv_d = (state_d == CNV_HIGH);
    clk_d = (state_d == CLOCKING) && !cnt_d[1];
    if (state_d == DONE) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge sys_clk_int or posedge reset_int) begin
    if (reset_int) begin
      cond_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      ev_cnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      cnv_q    <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      cond_q   <= cond_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ev_cnt_q <= ev_cnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      cnv_q    <= cnv_d;
      clk_q    <= clk_d;
    end
  end

  assign adc.cnv            = cnv_q;
  assign adc.clk            = clk_q;
  assign adc.tl             = 1'b1;
  assign adc.adc_data_out   = data_q;
  assign adc.adc_data_valid = valid_q;

endmodule

// File: tb/tb_ltc2387_adc_interface.sv
`timescale 1ns/100ps
// Directed bench for ltc2387_adc_interface with an inline virtual_adc model
// that serves 18'h2AAAA / 18'h15555 alternately over the DA/DB/DCO lanes.
module tb_ltc2387_adc_interface;

  localparam int          ADC_WIDTH   = 18;
  localparam int          NUM_SAMPLES = 2;
  localparam logic [17:0] SAMPLE0     = 18'h2AAAA;
  localparam logic [17:0] SAMPLE1     = 18'h15555;

  logic sys_clk;
  logic reset;
  logic trig;
  logic connected;
  int   errors = 0;
  int   checks = 0;

  ltc2387_adc_interface_if #(.ADC_WIDTH(ADC_WIDTH)) adc_if ();

  ltc2387_adc_interface #(.ADC_WIDTH(ADC_WIDTH)) dut (
    .sys_clk_int  (sys_clk),
    .reset_int    (reset),
    .data_clk_int (sys_clk),
    .trig_int     (trig),
    .adc          (adc_if)
  );

  initial sys_clk = 1'b0;
  always #2.5 sys_clk = ~sys_clk;

  // virtual_adc: latches a sample on CNV rise, drives bit pair k on clk edge k,
  // and echoes clk on dco one fast_clk (= sys_clk) cycle after the data.
  logic                 m_dco, m_da, m_db;
  logic                 m_cnv_prev, m_clk_seen;
  logic [ADC_WIDTH-1:0] m_word;
  int                   m_idx, m_k;

  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      m_dco <= 1'b0; m_da <= 1'b0; m_db <= 1'b0;
      m_cnv_prev <= 1'b0; m_clk_seen <= 1'b0;
      m_word <= '0; m_idx <= 0; m_k <= 0;
    end else begin
      m_cnv_prev <= adc_if.cnv;
      if (adc_if.cnv && !m_cnv_prev) begin
        m_word <= (m_idx == 0) ? SAMPLE0 : SAMPLE1;
        m_idx  <= (m_idx + 1) % NUM_SAMPLES;
        m_k    <= 0;
      end
      m_clk_seen <= adc_if.clk;
      if (adc_if.clk != m_clk_seen) begin
        if (m_k < ADC_WIDTH / 2) begin
          m_da <= m_word[ADC_WIDTH-1-2*m_k];
          m_db <= m_word[ADC_WIDTH-2-2*m_k];
        end
        m_k <= m_k + 1;
      end
      m_dco <= m_clk_seen;
    end
  end

  assign adc_if.dco = connected & m_dco;
  assign adc_if.da  = connected & m_da;
  assign adc_if.db  = connected & m_db;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one conversion from a 2-cycle trig pulse; call right after a negedge.
  task automatic convert(input string tag, input logic [17:0] exp_word, input bit busy_trig);
    int          cnv_rise  = -1;
    int          clk_first = -1;
    int          valid_at  = -1;
    int          cnv_hi    = 0;
    int          clk_rises = 0;
    int          clk_hi    = 0;
    int          valid_cnt = 0;
    int          run       = 0;
    int          bad_phase = 0;
    logic        prev_cnv  = 1'b0;
    logic        prev_clk  = 1'b0;
    logic [17:0] got       = '0;
    trig = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      if (c == 1) trig = 1'b0;
      if (busy_trig && cnv_rise >= 0 && c == cnv_rise + 20) trig = 1'b1;
      if (busy_trig && cnv_rise >= 0 && c == cnv_rise + 22) trig = 1'b0;
      if (adc_if.cnv && !prev_cnv && cnv_rise < 0) cnv_rise = c;
      if (adc_if.cnv) cnv_hi++;
      if (adc_if.clk != prev_clk) begin
        if (clk_first >= 0 && run != 2) bad_phase++;
        run = 1;
      end else begin
        run++;
      end
      if (adc_if.clk && !prev_clk) begin
        clk_rises++;
        if (clk_first < 0) clk_first = c;
      end
      if (adc_if.clk) clk_hi++;
      if (adc_if.adc_data_valid) begin
        valid_cnt++;
        got = adc_if.adc_data_out;
        if (valid_at < 0) valid_at = c;
      end
      prev_cnv = adc_if.cnv;
      prev_clk = adc_if.clk;
    end
    check({tag, "_cnv_rise_after_start"}, cnv_rise, 1);
    check({tag, "_cnv_high_cycles"}, cnv_hi, 2);
    check({tag, "_first_clk_delay"}, clk_first - cnv_rise, 13);
    check({tag, "_clk_pulses"}, clk_rises, 5);
    check({tag, "_clk_high_cycles"}, clk_hi, 10);
    check({tag, "_clk_phase_errors"}, bad_phase, 0);
    check({tag, "_valid_pulses"}, valid_cnt, 1);
    check({tag, "_valid_latency_ok"}, (valid_at >= 0) && (valid_at - cnv_rise <= 39), 1);
    check({tag, "_data"}, got, exp_word);
    check({tag, "_data_held"}, adc_if.adc_data_out, exp_word);
    check({tag, "_state_idle"}, dut.state_q, 0);
  endtask

  initial begin
    int n;
    int idle_at;
    int to_valid;
    bit busy_seen;
    reset     = 1'b1;
    trig      = 1'b0;
    connected = 1'b1;
    #21 reset = 1'b0;
    @(negedge sys_clk);
    check("rst_cnv", adc_if.cnv, 0);
    check("rst_clk", adc_if.clk, 0);
    check("rst_tl", adc_if.tl, 1);
    check("rst_data", adc_if.adc_data_out, 0);
    check("rst_valid", adc_if.adc_data_valid, 0);
    check("rst_state", dut.state_q, 0);

    convert("conv1", 18'h2AAAA, 1'b0);
    convert("conv2", 18'h15555, 1'b0);
    convert("conv3", 18'h2AAAA, 1'b0);
    convert("busy", 18'h15555, 1'b1);

    // Reset asserted while the CLK burst is running.
    trig = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    trig = 1'b0;
    n = 0;
    while (adc_if.clk !== 1'b1 && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (3) @(negedge sys_clk);
    check("mr_in_clocking", dut.state_q, 3);
    #1 reset = 1'b1;
    #0.5;
    check("mr_cnv", adc_if.cnv, 0);
    check("mr_clk", adc_if.clk, 0);
    check("mr_tl", adc_if.tl, 1);
    check("mr_data", adc_if.adc_data_out, 0);
    check("mr_valid", adc_if.adc_data_valid, 0);
    check("mr_state", dut.state_q, 0);
    #20;
    @(negedge sys_clk);
    #1 reset = 1'b0;
    @(negedge sys_clk);
    convert("post_reset", 18'h2AAAA, 1'b0);

    // ADC disconnected: no DCO edges, so WAIT_DATA must time out.
    connected = 1'b0;
    idle_at   = -1;
    to_valid  = 0;
    busy_seen = 1'b0;
    trig      = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge sys_clk);
      if (c == 1) trig = 1'b0;
      if (adc_if.adc_data_valid) to_valid++;
      if (dut.state_q != 0) busy_seen = 1'b1;
      else if (busy_seen && idle_at < 0) idle_at = c;
    end
    check("to_valid_pulses", to_valid, 0);
    check("to_idle_not_early", idle_at >= 50, 1);
    check("to_idle_in_bound", (idle_at >= 0) && (idle_at <= 51), 1);
    check("to_data_unchanged", adc_if.adc_data_out, 18'h2AAAA);

    // The timed-out conversion consumed 18'h15555 from the model.
    connected = 1'b1;
    repeat (2) @(negedge sys_clk);
    convert("recover", 18'h2AAAA, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ltc2387_adc_interface.md
# ltc2387_adc_interface

FPGA-side controller for an LTC2387-18 style SAR ADC in two-lane, DDR-output mode. A trigger starts one conversion. The block drives CNV and a gated serial CLK burst to the ADC, then deserialises the DA/DB lanes, which are qualified by the echoed DCO, into a parallel word with a one-cycle valid strobe. It sits between the ADC pins and the acquisition logic, in a single 200 MHz clock domain.

## Interface
- ADC_WIDTH, 18: conversion word width; must be even; bits per lane are ADC_WIDTH/2.
- SYS_CLK_FREQ, 200_000_000: sys_clk_int frequency in Hz.
- T_FIRSTCLK, (65*SYS_CLK_FREQ)/1e9 = 13: number of cycles from CNV rising to the first CLK rising edge.
- CNV_HIGH_CYCLES, 2: CNV high width in cycles.
- TIMEOUT_CYCLES, 16: maximum wait for the remaining DCO edges after the CLK burst.

Ports:
- sys_clk_int  in  1  the only clock; all logic is on its rising edge.
- reset_int  in  1  asynchronous, active-high reset.
- data_clk_int  in  1  must be tied to the same net as sys_clk_int; carries no independent timing.
- trig_int  in  1  conversion request; its rising edge starts a conversion.
- dco  in  1  data clock echoed by the ADC.
- da  in  1  lane A data: D17, D15, …, D1.
- db  in  1  lane B data: D16, D14, …, D0.
- cnv  out  1  conversion start to the ADC.
- clk  out  1  serial clock to the ADC; idles low.
- tl  out  1  two-lane select; constant 1.
- adc_data_out  out  ADC_WIDTH  last captured word; held between conversions.
- adc_data_valid  out  1  one-cycle strobe, asserted in the cycle adc_data_out updates.

## Operation
- Input conditioning:
  - trig_int is registered once; a start is a rising edge (registered high, previous low).
  - dco, da and db pass through an identical 2-FF synchroniser chain, then one more dco stage for edge detection.
  - Any change of the synchronised dco, rising or falling, is a capture event.
- State register `state`, 3 bits:
  - IDLE=0: waits for a start; starts during any other state are ignored.
  - CNV_HIGH=1: cnv=1 for CNV_HIGH_CYCLES cycles.
  - WAIT_FIRST=2: cnv=0; the counter that began at CNV rising reaches T_FIRSTCLK.
  - CLOCKING=3: clk toggles every 2 cycles (period 4 cycles, 50 MHz). Runs for ceil(ADC_WIDTH/4) pulses, which is 5 pulses / 20 cycles for 18 bits. Ends with clk low.
  - WAIT_DATA=4: waits until ADC_WIDTH/2 capture events have occurred since the conversion started. Events may already arrive in CLOCKING.
  - DONE=5: for one cycle, loads the shift register into adc_data_out and pulses adc_data_valid; then returns to IDLE.
- Capture and word assembly:
  - On each capture event k = 0..ADC_WIDTH/2-1, both lanes shift in MSB-first: da goes to bit ADC_WIDTH-1-2k and db to bit ADC_WIDTH-2-2k.
  - Events beyond ADC_WIDTH/2 (the final falling DCO edge) are ignored.
  - The event counter clears on entry to CNV_HIGH.
- Timeout: if WAIT_DATA lasts TIMEOUT_CYCLES cycles without completing, return to IDLE. No valid pulse is issued and adc_data_out is unchanged.
- Reset, asynchronous, takes effect immediately including mid-conversion:
  - state=IDLE, cnv=0, clk=0, tl=1.
  - adc_data_out=0, adc_data_valid=0.
  - All counters and synchronisers cleared.
- Bench ADC model, virtual_adc: parameters ADC_WIDTH and NUM_SAMPLES; ports clk, reset, cnv, dco, da, db, fast_clk.
  - On CNV rising, it latches the next stored sample, cycling through NUM_SAMPLES values. Sample 0 = 18'h2AAAA, sample 1 = 18'h15555.
  - On each clk edge k it drives da/db with bit pair k.
  - dco follows clk one fast_clk cycle later, so data is stable before the dco edge.
  - Reset: dco=0, da=0, db=0, sample index 0.

## Timing
- cnv rises one cycle after the start edge is registered.
- First clk rise occurs T_FIRSTCLK cycles after cnv rises.
- Synchroniser plus edge-detect latency is 3 cycles from a pin change to the capture event.
- adc_data_valid asserts at most T_FIRSTCLK + 20 + 6 cycles after cnv rises, i.e. ≤ 39 cycles with the defaults.
- Back-to-back rate: a new start is accepted in the cycle after DONE.
- clk never glitches; its high and low phases are each exactly 2 cycles.

## Test plan
- Reset test: hold reset 20 ns, release -> cnv=0, clk=0, tl=1, adc_data_out=0, adc_data_valid=0, state=0.
- First conversion with the model: trig pulsed high for 2 cycles ->
  - cnv high for exactly 2 cycles, first clk rise 13 cycles after cnv rises, exactly 5 clk pulses;
  - adc_data_valid is a single-cycle pulse with adc_data_out=18'h2AAAA.
- Second trigger -> adc_data_out=18'h15555; a third trigger wraps to 18'h2AAAA.
- Trigger while busy: a second trig edge during CLOCKING -> ignored; exactly one valid pulse.
- Reset mid-conversion: assert reset during CLOCKING ->
  - outputs go to reset values immediately;
  - the next trigger after release produces a correct word.
- Timeout: model disconnected (dco held 0), then trig -> no valid pulse, state back at 0 within 13+20+16+2 cycles, adc_data_out unchanged.
